// File: rtl/foc_pkg.sv
// Types and constants shared by the FOC datapath: carrier direction, the
// three-phase duty triple handed from svpwm to the modulator, and the carrier peak.
package foc_pkg;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } carrier_dir_e;

    // Widest duty any modulator instance may use; narrower instances zero-extend.
    localparam int DUTY_W = 16;

    typedef struct packed {
        logic [DUTY_W-1:0] a;
        logic [DUTY_W-1:0] b;
        logic [DUTY_W-1:0] c;
    } duty3_t;

    function automatic int unsigned PWM_MAX(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_modulator_if.sv
// Bus between the control loop and the PWM modulator: duty load strobe, enable,
// gate outputs, sync pulses, and the carrier state for observation.
interface pwm_modulator_if #(parameter int WIDTH = 8);
    import foc_pkg::*;

    // duty_valid has no ready: the shadow registers accept every cycle, so each
    // cycle with duty_valid high is one completed transfer of da_on/db_on/dc_on.
    logic             en;
    logic [WIDTH-1:0] da_on;
    logic [WIDTH-1:0] db_on;
    logic [WIDTH-1:0] dc_on;
    logic             duty_valid;
    logic             ha, la, hb, lb, hc, lc;
    logic             period_start;
    logic             period_mid;
    logic [WIDTH-1:0] cnt;
    carrier_dir_e     dir;

    modport master (
        output en, da_on, db_on, dc_on, duty_valid,
        input  ha, la, hb, lb, hc, lc, period_start, period_mid, cnt, dir
    );

    modport slave (
        input  en, da_on, db_on, dc_on, duty_valid,
        output ha, la, hb, lb, hc, lc, period_start, period_mid, cnt, dir
    );

endinterface

// File: rtl/pwm_deadtime.sv
// One half-bridge: turns the phase reference into complementary gates with a
// saturating stable counter that delays every gate turn-on by DEADTIME cycles.
module pwm_deadtime #(
    parameter int DEADTIME = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic ref_nxt,
    input  logic ref_cur,
    output logic h,
    output logic l
);

    localparam logic [7:0] DT = 8'(DEADTIME);

    logic [7:0] stable;
    logic [7:0] stable_nxt;
    logic       settled;

    // ref_nxt is the D input of the reference register, so gates react in the
    // same edge that the registered reference changes.
    always_comb begin
        stable_nxt = stable;
        if (ref_nxt != ref_cur) begin
            stable_nxt = '0;
        end else if (stable != DT) begin
            stable_nxt = stable + 8'd1;
        end
        settled = (stable_nxt == DT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            h      <= 1'b0;
            l      <= 1'b0;
        end else if (!en) begin
            stable <= '0;
            h      <= 1'b0;
            l      <= 1'b0;
        end else begin
            stable <= stable_nxt;
            h      <= ref_nxt & settled;
            l      <= ~ref_nxt & settled;
        end
    end

endmodule

// File: rtl/pwm_modulator.sv
// Three-phase center-aligned PWM: up/down carrier, valley-aligned duty double
// buffering, per-phase compare and dead-time insertion.
module pwm_modulator
    import foc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEADTIME = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_modulator_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(PWM_MAX(WIDTH));

    carrier_dir_e     dir;
    carrier_dir_e     dir_nxt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;

    duty3_t            shadow;
    duty3_t            active;
    logic [DUTY_W-1:0] cnt_ext;
    logic [2:0]        cmp;
    logic [2:0]        refs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dir <= UP;
        end else begin
            cnt <= cnt_nxt;
            dir <= dir_nxt;
        end
    end

    // dir already reads DOWN while cnt sits at the peak and UP at the valley.
    always_comb begin
        cnt_nxt = (dir == UP) ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
        dir_nxt = dir;
        if (cnt_nxt == MAX) begin
            dir_nxt = DOWN;
        end else if (cnt_nxt == '0) begin
            dir_nxt = UP;
        end
    end

    assign bus.period_start = (cnt == '0);
    assign bus.period_mid   = (cnt == MAX);
    assign bus.cnt          = cnt;
    assign bus.dir          = dir;

    // The valley reload takes the shadow as it was before this cycle's strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (bus.duty_valid) begin
                shadow <= '{a: DUTY_W'(bus.da_on), b: DUTY_W'(bus.db_on), c: DUTY_W'(bus.dc_on)};
            end
            if (cnt == '0) begin
                active <= shadow;
            end
        end
    end

    assign cnt_ext = DUTY_W'(cnt);
    assign cmp[0]  = (cnt_ext < active.a);
    assign cmp[1]  = (cnt_ext < active.b);
    assign cmp[2]  = (cnt_ext < active.c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refs <= '0;
        end else begin
            refs <= cmp;
        end
    end

    pwm_deadtime #(.DEADTIME(DEADTIME)) u_dt_a (
        .clk(clk), .rst_n(rst_n), .en(bus.en),
        .ref_nxt(cmp[0]), .ref_cur(refs[0]), .h(bus.ha), .l(bus.la)
    );

    pwm_deadtime #(.DEADTIME(DEADTIME)) u_dt_b (
        .clk(clk), .rst_n(rst_n), .en(bus.en),
        .ref_nxt(cmp[1]), .ref_cur(refs[1]), .h(bus.hb), .l(bus.lb)
    );

    pwm_deadtime #(.DEADTIME(DEADTIME)) u_dt_c (
        .clk(clk), .rst_n(rst_n), .en(bus.en),
        .ref_nxt(cmp[2]), .ref_cur(refs[2]), .h(bus.hc), .l(bus.lc)
    );

endmodule
